conv_output_stream_sink: RTL and testbench

Consumer end of the accelerator's output stream. It captures the `write_valid`/`write` beat stream that a generated kernel (e.g. `conv_3_3`) emits on its `hw_output_stencil` port, and counts beats against a fixed frame size. It folds the data into a running checksum and reports frame completion, stall timeout and overrun. It sits beside the DUT in power/flow benches and at the top of hardware test wrappers, so output activity is actually consumed and checkable instead of left dangling.

---
 rtl/stream_sink_pkg.sv | 24 ++
 rtl/conv_output_stream_sink_stall_timer.sv | 27 ++
 rtl/conv_output_stream_sink.sv | 109 ++++++++++
 tb/tb_conv_output_stream_sink.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_sink_pkg.sv
// stream_sink_pkg: shared FSM state type and checksum step for conv_output_stream_sink
package stream_sink_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ERR
    } sink_state_e;

    localparam int CKSUM_MAX_W = 64;

    // Rotate-left-by-one of the low w bits, then XOR in the new beat.
    function automatic logic [CKSUM_MAX_W-1:0] cksum_step(
        input logic [CKSUM_MAX_W-1:0] sum,
        input logic [CKSUM_MAX_W-1:0] data,
        input int                     w
    );
        logic [CKSUM_MAX_W-1:0] mask;
        mask = (w >= CKSUM_MAX_W) ? '1 : ((CKSUM_MAX_W'(1) << w) - CKSUM_MAX_W'(1));
        return (((sum << 1) | (sum >> (w - 1))) ^ data) & mask;
    endfunction

endpackage

// File: rtl/conv_output_stream_sink_stall_timer.sv
// stall_timer: counts consecutive idle ticks and flags the tick that reaches TIMEOUT
module stall_timer #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] idle_cnt;

    // Idle counter: clear wins, otherwise count ticks and saturate at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (clear)
            idle_cnt <= '0;
        else if (tick && idle_cnt != CW'(TIMEOUT))
            idle_cnt <= idle_cnt + CW'(1);
    end

    assign expired = tick && !clear && (idle_cnt >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/conv_output_stream_sink.sv
// conv_output_stream_sink: frame beat counter/checksum sink; STREAM_SINK_MINMAX_EN adds min/max tracking
module conv_output_stream_sink
    import stream_sink_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int FRAME_BEATS = 3844,
    parameter int TIMEOUT     = 4096,
    localparam int BW         = $clog2(FRAME_BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              overrun_err,
    output logic [BW-1:0]     beat_count,
    output logic [DATA_W-1:0] checksum,
    output logic [DATA_W-1:0] data_min,
    output logic [DATA_W-1:0] data_max
);
    sink_state_e state, state_n;
    logic        ctrl_free, accept, last_beat, overrun, tick, stall;

    stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!tick),
        .tick    (tick),
        .expired (stall)
    );

    // Next state: flush beats start, start beats per-state beat/stall handling.
    always_comb begin
        ctrl_free = !flush && !start;
        accept    = ctrl_free && state == S_RUN && in_valid;
        last_beat = accept && beat_count == BW'(FRAME_BEATS - 1);
        overrun   = ctrl_free && state == S_DONE && in_valid;
        tick      = ctrl_free && state == S_RUN && !in_valid;
        state_n   = flush ? S_IDLE :
                    start ? S_RUN :
                    last_beat ? S_DONE :
                    (stall || overrun) ? S_ERR : state;
    end

    // State register with busy registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= state_n == S_RUN;
        end
    end

    // Frame datapath: beat count, checksum and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count  <= '0;
            checksum    <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else if (flush || start) begin
            beat_count  <= '0;
            checksum    <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (accept) begin
                beat_count <= beat_count + BW'(1);
                checksum   <= DATA_W'(cksum_step(CKSUM_MAX_W'(checksum), CKSUM_MAX_W'(in_data), DATA_W));
            end
            if (last_beat)
                done <= 1'b1;
            if (stall)
                timeout_err <= 1'b1;
            if (overrun)
                overrun_err <= 1'b1;
        end
    end

`ifdef STREAM_SINK_MINMAX_EN
    // Unsigned extrema over accepted beats, reopened on every start/flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_min <= '1;
            data_max <= '0;
        end else if (flush || start) begin
            data_min <= '1;
            data_max <= '0;
        end else if (accept) begin
            if (in_data < data_min)
                data_min <= in_data;
            if (in_data > data_max)
                data_max <= in_data;
        end
    end
`else
    assign data_min = '1;
    assign data_max = '0;
`endif

endmodule

// File: tb/tb_conv_output_stream_sink.sv
// tb_conv_output_stream_sink: randomized scoreboard bench for conv_output_stream_sink
module tb_conv_output_stream_sink;
    localparam int DW = 16;
    localparam int FB = 4;
    localparam int TO = 8;
    localparam int BW = $clog2(FB + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          busy, done, timeout_err, overrun_err;
    logic [BW-1:0] beat_count;
    logic [DW-1:0] checksum, data_min, data_max;

    conv_output_stream_sink #(.DATA_W(DW), .FRAME_BEATS(FB), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err),
        .beat_count  (beat_count),
        .checksum    (checksum),
        .data_min    (data_min),
        .data_max    (data_max)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0] cnt;
        logic [DW-1:0] cks;
        logic          done;
        logic          terr;
        logic          oerr;
        logic          busy;
        logic [DW-1:0] dmin;
        logic [DW-1:0] dmax;
    } obs_t;

    localparam obs_t RESET_OBS = '{cnt: '0, cks: '0, done: 1'b0, terr: 1'b0, oerr: 1'b0,
                                   busy: 1'b0, dmin: '1, dmax: '0};

    obs_t exp_q[$];
    obs_t exp_e;
    int   checks = 0;
    int   passes = 0;
    logic pd = 1'b0, pt = 1'b0, po = 1'b0;

    function automatic obs_t observe();
        return '{cnt: beat_count, cks: checksum, done: done, terr: timeout_err, oerr: overrun_err,
                 busy: busy, dmin: data_min, dmax: data_max};
    endfunction

    // Reference: result of a frame whose accepted beats are b, ending by kind
    // (0 = completed, 1 = stalled, 2 = completed then overrun).
    function automatic obs_t model(input logic [DW-1:0] b[$], input int kind);
        obs_t    o;
        int      c = 0;
        int      mn = (1 << DW) - 1;
        int      mx = 0;
        foreach (b[i]) begin
            c = ((c * 2) % (1 << DW)) + (c / (1 << (DW - 1)));
            c = c ^ int'(b[i]);
            if (int'(b[i]) < mn) mn = int'(b[i]);
            if (int'(b[i]) > mx) mx = int'(b[i]);
        end
        o.cnt  = BW'(b.size());
        o.cks  = DW'(c);
        o.done = kind != 1;
        o.terr = kind == 1;
        o.oerr = kind == 2;
        o.busy = 1'b0;
`ifdef STREAM_SINK_MINMAX_EN
        o.dmin = DW'(mn);
        o.dmax = DW'(mx);
`else
        o.dmin = '1;
        o.dmax = '0;
`endif
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input bit v0);
        start    = 1'b1;
        in_valid = v0;
        in_data  = DW'($urandom);
        cyc();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic beat(input int gap, input logic [DW-1:0] d);
        in_valid = 1'b0;
        cyc(gap);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic frame(input logic [DW-1:0] b[$], input int glo, input int ghi, input bit v0);
        exp_q.push_back(model(b, 0));
        do_start(v0);
        if (v0) check("start_beat_dropped", 64'(beat_count), 64'(0));
        foreach (b[i]) beat($urandom_range(ghi, glo), b[i]);
    endtask

    task automatic stall_frame(input logic [DW-1:0] b[$]);
        exp_q.push_back(model(b, 1));
        do_start(1'b0);
        foreach (b[i]) beat($urandom_range(TO - 1, 0), b[i]);
        cyc(TO);
    endtask

    task automatic overrun_beat(input logic [DW-1:0] b[$], input logic [DW-1:0] d);
        exp_q.push_back(model(b, 2));
        beat($urandom_range(3, 0), d);
    endtask

    // Monitor: every fresh completion/error event consumes one expected result.
    always @(negedge clk) begin
        if ((done && !pd) || (timeout_err && !pt) || (overrun_err && !po)) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_event: got done=%b terr=%b oerr=%b expected none",
                         done, timeout_err, overrun_err);
            end else begin
                exp_e = exp_q.pop_front();
                check("scoreboard", 64'(observe()), 64'(exp_e));
            end
        end
        pd = done;
        pt = timeout_err;
        po = overrun_err;
    end

    logic [DW-1:0] bq[$];

    initial begin
        #2;
        check("reset_values", 64'(observe()), 64'(RESET_OBS));
        cyc(2);
        rst_n = 1'b1;
        cyc();
        in_valid = 1'b1;
        in_data  = 16'h1234;
        cyc(3);
        in_valid = 1'b0;
        check("idle_ignores_beats", 64'(observe()), 64'(RESET_OBS));

        bq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        frame(bq, 0, 0, 1'b0);
        check("clean_checksum", 64'(checksum), 64'(16'h0002));
        check("clean_count", 64'(beat_count), 64'(4));
        check("clean_flags", 64'({done, busy, timeout_err, overrun_err}), 64'(4'b1000));
`ifdef STREAM_SINK_MINMAX_EN
        check("clean_extrema", 64'({data_min, data_max}), 64'({16'h0001, 16'h0004}));
`else
        check("clean_extrema", 64'({data_min, data_max}), 64'({16'hFFFF, 16'h0000}));
`endif
        overrun_beat(bq, 16'h00FF);
        check("overrun_freeze", 64'({overrun_err, done, checksum}), 64'({2'b11, 16'h0002}));
        cyc(2);

        exp_q.push_back(model(bq, 0));
        do_start(1'b0);
        foreach (bq[i]) beat(7, bq[i]);
        check("gapped_no_timeout", 64'({done, timeout_err, checksum}), 64'({2'b10, 16'h0002}));
        cyc(2);

        bq = {};
        stall_frame(bq);
        check("stall_state", 64'({timeout_err, busy, beat_count}), 64'({2'b10, BW'(0)}));
        cyc(2);

        bq = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        frame(bq, 0, 2, 1'b1);
        cyc(2);

        flush = 1'b1;
        start = 1'b1;
        cyc();
        flush = 1'b0;
        start = 1'b0;
        check("flush_over_start", 64'(observe()), 64'(RESET_OBS));

        do_start(1'b0);
        beat(0, 16'hABCD);
        beat(0, 16'h0042);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'(observe()), 64'(RESET_OBS));
        #2;
        rst_n = 1'b1;
        cyc(2);

        for (int it = 0; it < 40; it++) begin
            int kind = $urandom_range(2, 0);
            bq = {};
            if (kind == 1) begin
                int k = $urandom_range(FB - 1, 0);
                for (int j = 0; j < k; j++) bq.push_back(DW'($urandom));
                stall_frame(bq);
            end else begin
                for (int j = 0; j < FB; j++) bq.push_back(DW'($urandom));
                frame(bq, 0, TO - 1, 1'($urandom_range(1, 0)));
                if (kind == 2) overrun_beat(bq, DW'($urandom));
            end
            cyc($urandom_range(3, 1));
        end

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) cyc();
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
